// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the branch resolution controller.
package branch_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      FLUSH    = 2'd2
   } brctl_state_t;

   localparam int unsigned PC_STEP   = 4;
   // Sliced to the datapath width by users; clears bit 0 of a JALR target.
   localparam logic [63:0] JALR_MASK = ~64'd1;

endpackage

// File: rtl/branch_target.sv
// Combinational target/sequential PC selection and misalignment detection.
module branch_target
   import branch_ctrl_pkg::*;
#(
   parameter int unsigned DWIDTH = 32
) (
   input  logic              br_jump_i,
   input  logic              br_jalr_i,
   input  logic              br_taken_i,
   input  logic              br_pred_i,
   input  logic [DWIDTH-1:0] br_pc_i,
   input  logic [DWIDTH-1:0] br_rs1_i,
   input  logic [DWIDTH-1:0] br_imm_i,
   output logic [DWIDTH-1:0] newpc_o,
   output logic              take_o,
   output logic              mispredict_o,
   output logic              misalign_o
);

   logic [DWIDTH-1:0] base;
   logic [DWIDTH-1:0] tgt;
   logic [DWIDTH-1:0] seq;

   always_comb begin
      base = br_jalr_i ? br_rs1_i : br_pc_i;
      tgt  = base + br_imm_i;
      if (br_jalr_i) begin
         tgt = tgt & JALR_MASK[DWIDTH-1:0];
      end
      seq          = br_pc_i + DWIDTH'(PC_STEP);
      take_o       = br_jump_i | br_taken_i;
      mispredict_o = br_jump_i | (br_taken_i ^ br_pred_i);
      newpc_o      = take_o ? tgt : seq;
      misalign_o   = take_o & tgt[1];
   end

endmodule

// File: rtl/branch_ctrl.sv
// Branch/jump resolution sequencer: mispredict redirect handshake plus flush window.
// Optional statistics counters are enabled by defining BRANCH_CTRL_STATS_EN.
module branch_ctrl
   import branch_ctrl_pkg::*;
#(
   parameter int unsigned DWIDTH       = 32,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              br_valid,
   output logic              br_ready,
   input  logic              br_jump,
   input  logic              br_jalr,
   input  logic              br_taken,
   input  logic              br_pred,
   input  logic [DWIDTH-1:0] br_pc,
   input  logic [DWIDTH-1:0] br_rs1,
   input  logic [DWIDTH-1:0] br_imm,
   output logic              redirect_valid,
   input  logic              redirect_ready,
   output logic [DWIDTH-1:0] redirect_pc,
   output logic              flush_ifid,
   output logic              flush_idex,
   output logic              stall_ex,
   output logic              misalign_err
`ifdef BRANCH_CTRL_STATS_EN
   ,
   output logic [31:0]       stat_branches,
   output logic [31:0]       stat_mispredicts
`endif
);

   brctl_state_t      state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [DWIDTH-1:0] pc_q, pc_d;
   logic              mis_q, mis_d;

   logic [DWIDTH-1:0] newpc;
   logic              take;
   logic              mispredict;
   logic              misalign;
   logic              accept;

   branch_target #(
      .DWIDTH (DWIDTH)
   ) u_target (
      .br_jump_i    (br_jump),
      .br_jalr_i    (br_jalr),
      .br_taken_i   (br_taken),
      .br_pred_i    (br_pred),
      .br_pc_i      (br_pc),
      .br_rs1_i     (br_rs1),
      .br_imm_i     (br_imm),
      .newpc_o      (newpc),
      .take_o       (take),
      .mispredict_o (mispredict),
      .misalign_o   (misalign)
   );

   assign accept = br_valid & (state_q == IDLE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_d    = pc_q;
      mis_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (take && misalign) begin
                  mis_d = 1'b1;
               end else if (mispredict) begin
                  pc_d    = newpc;
                  state_d = REDIRECT;
               end
            end
         end
         REDIRECT: begin
            if (redirect_ready) begin
               if (FLUSH_CYCLES > 1) begin
                  state_d = FLUSH;
                  cnt_d   = 4'(FLUSH_CYCLES - 1);
               end else begin
                  state_d = IDLE;
               end
            end
         end
         FLUSH: begin
            // Leaving as cnt reaches 0 keeps FLUSH at FLUSH_CYCLES-1 cycles.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pc_q    <= '0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
         mis_q   <= mis_d;
      end
   end

   assign br_ready       = (state_q == IDLE);
   assign redirect_valid = (state_q == REDIRECT);
   assign flush_ifid     = (state_q == REDIRECT) || (state_q == FLUSH);
   assign flush_idex     = (state_q == REDIRECT) || (state_q == FLUSH);
   assign stall_ex       = (state_q == REDIRECT);
   assign redirect_pc    = pc_q;
   assign misalign_err   = mis_q;

`ifdef BRANCH_CTRL_STATS_EN
   logic [31:0] stat_br_q, stat_mp_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_br_q <= '0;
         stat_mp_q <= '0;
      end else begin
         if (accept) begin
            stat_br_q <= stat_br_q + 32'd1;
         end
         if ((state_q == IDLE) && (state_d == REDIRECT)) begin
            stat_mp_q <= stat_mp_q + 32'd1;
         end
      end
   end

   assign stat_branches    = stat_br_q;
   assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: stimulus queues expected redirects, a monitor checks them.
module tb_branch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        br_valid, br_ready, br_jump, br_jalr, br_taken, br_pred;
   logic [31:0] br_pc, br_rs1, br_imm;
   logic        redirect_valid, redirect_ready;
   logic [31:0] redirect_pc;
   logic        flush_ifid, flush_idex, stall_ex, misalign_err;
`ifdef BRANCH_CTRL_STATS_EN
   logic [31:0] stat_branches, stat_mispredicts;
`endif

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;
   logic [31:0] exp_q[$];
   int unsigned mis_q[$];

   always #5 clk = ~clk;

   branch_ctrl #(
      .DWIDTH       (32),
      .FLUSH_CYCLES (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .br_valid       (br_valid),
      .br_ready       (br_ready),
      .br_jump        (br_jump),
      .br_jalr        (br_jalr),
      .br_taken       (br_taken),
      .br_pred        (br_pred),
      .br_pc          (br_pc),
      .br_rs1         (br_rs1),
      .br_imm         (br_imm),
      .redirect_valid (redirect_valid),
      .redirect_ready (redirect_ready),
      .redirect_pc    (redirect_pc),
      .flush_ifid     (flush_ifid),
      .flush_idex     (flush_idex),
      .stall_ex       (stall_ex),
      .misalign_err   (misalign_err)
`ifdef BRANCH_CTRL_STATS_EN
      ,
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one branch; waits (bounded) for br_ready, holds br_valid for one accepting edge.
   task automatic issue(input logic j, input logic jr, input logic tk, input logic pr,
                        input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] imm,
                        input logic exp_redir, input logic [31:0] exp_pc, input logic exp_mis);
      int unsigned waited = 0;
      while (!br_ready && waited < 50) begin
         tick();
         waited++;
      end
      if (!br_ready) chk("br_ready_timeout", {31'd0, br_ready}, 32'd1);
      br_jump = j; br_jalr = jr; br_taken = tk; br_pred = pr;
      br_pc = pc; br_rs1 = rs1; br_imm = imm;
      br_valid = 1'b1;
      if (exp_redir) exp_q.push_back(exp_pc);
      if (exp_mis) mis_q.push_back(1);
      tick();
      br_valid = 1'b0;
   endtask

   // Counts flush cycles until br_ready returns (bounded).
   task automatic count_flush(input string name, input int unsigned expected);
      int unsigned cnt = 0;
      for (int i = 0; i < 30; i++) begin
         if (br_ready) break;
         if (flush_ifid && flush_idex) cnt++;
         tick();
      end
      chk({name, "_flush_cycles"}, cnt, expected);
      chk({name, "_ready_back"}, {31'd0, br_ready}, 32'd1);
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!reset && redirect_valid && redirect_ready) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_redirect: got pc %h expected none", redirect_pc);
            end else begin
               chk("redirect_pc", redirect_pc, exp_q.pop_front());
            end
         end
         if (!reset && misalign_err) begin
            if (mis_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_misalign: got 1 expected 0");
            end else begin
               chk("misalign_pulse", {31'd0, misalign_err}, 32'(mis_q.pop_front()));
            end
         end
      end
   end

   initial begin : stim
      reset = 1'b1; br_valid = 1'b0; br_jump = 1'b0; br_jalr = 1'b0;
      br_taken = 1'b0; br_pred = 1'b0; br_pc = '0; br_rs1 = '0; br_imm = '0;
      redirect_ready = 1'b0;
      tick(); tick();
      chk("rst_br_ready", {31'd0, br_ready}, 32'd1);
      chk("rst_outs", {27'd0, redirect_valid, flush_ifid, flush_idex, stall_ex, misalign_err}, 32'd0);
      reset = 1'b0;
      tick();

      // 1: taken, predicted not-taken
      redirect_ready = 1'b1;
      issue(0, 0, 1, 0, 32'h100, 0, 32'h20, 1, 32'h120, 0);
      chk("t1_redirect_valid", {31'd0, redirect_valid}, 32'd1);
      chk("t1_stall", {31'd0, stall_ex}, 32'd1);
      count_flush("t1", 2);

      // 2: not-taken mispredict, then correct prediction
      issue(0, 0, 0, 1, 32'h200, 0, 32'h40, 1, 32'h204, 0);
      count_flush("t2a", 2);
      issue(0, 0, 1, 1, 32'h300, 0, 32'h40, 0, 0, 0);
      chk("t2b_no_redirect", {29'd0, redirect_valid, flush_ifid, br_ready}, 32'd1);

      // 3: JALR misaligned target, then aligned JALR
      issue(1, 1, 0, 0, 32'h50, 32'h1003, 32'h4, 0, 0, 1);
      chk("t3a_no_redirect", {30'd0, redirect_valid, br_ready}, 32'd1);
      tick();
      chk("t3a_pulse_end", {31'd0, misalign_err}, 32'd0);
      issue(1, 1, 0, 0, 32'h60, 32'h1001, 32'h3, 1, 32'h1004, 0);
      count_flush("t3b", 2);

      // 4: fetch stalls the redirect; a second branch must not be accepted
      redirect_ready = 1'b0;
      issue(0, 0, 1, 0, 32'h400, 0, 32'h10, 1, 32'h410, 0);
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin
            br_valid = 1'b1; br_pc = 32'h500; br_imm = 32'h80; br_taken = 1'b1; br_pred = 1'b0;
         end
         if (c == 3) br_valid = 1'b0;
         chk("t4_hold", {27'd0, redirect_valid, flush_ifid, flush_idex, stall_ex, br_ready}, 32'h1E);
         chk("t4_pc_stable", redirect_pc, 32'h410);
         tick();
      end
      redirect_ready = 1'b1;
      tick();
      count_flush("t4", 1);

      // 5: target wraps
      issue(0, 0, 1, 0, 32'hFFFF_FFF0, 0, 32'h20, 1, 32'h10, 0);
      count_flush("t5", 2);

      // 6: reset during REDIRECT
      redirect_ready = 1'b0;
      issue(0, 0, 1, 0, 32'h600, 0, 32'h8, 1, 32'h608, 0);
      chk("t6_in_redirect", {31'd0, redirect_valid}, 32'd1);
`ifdef BRANCH_CTRL_STATS_EN
      chk("stat_branches", stat_branches, 32'd8);
      chk("stat_mispredicts", stat_mispredicts, 32'd6);
`endif
      reset = 1'b1;
      #1;
      chk("t6_rst_ready", {31'd0, br_ready}, 32'd1);
      chk("t6_rst_outs", {27'd0, redirect_valid, flush_ifid, flush_idex, stall_ex, misalign_err}, 32'd0);
      chk("t6_rst_pc", redirect_pc, 32'd0);
`ifdef BRANCH_CTRL_STATS_EN
      chk("t6_stat_br_zero", stat_branches, 32'd0);
      chk("t6_stat_mp_zero", stat_mispredicts, 32'd0);
`endif
      exp_q.delete();
      tick();
      redirect_ready = 1'b1;
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("t6_no_redirect", {31'd0, redirect_valid}, 32'd0);
      end

      chk("scoreboard_drained", exp_q.size() + mis_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Sequences branch/jump resolution in the RISC-V core. Takes the resolved EX-stage outcome from the branch signal generator (brnch) and the fetch-time prediction.
- Detects mispredicts, computes the corrected PC, runs the redirect handshake to fetch, and drives pipeline flush/stall for a fixed window.
- Sits between the EX stage, the branch signal generator and the fetch/PC unit.

Parameters:
- DWIDTH, 32, datapath/PC width.
- FLUSH_CYCLES, 2, cycles flush stays asserted after redirect acceptance; legal range 1..15.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- br_valid  in  1  EX holds a resolved branch/jump this cycle.
- br_ready  out  1  controller can accept br_valid.
- br_jump  in  1  1 = JAL/JALR (unconditional), 0 = conditional branch.
- br_jalr  in  1  1 = JALR; target base is br_rs1.
- br_taken  in  1  brnch from the branch signal generator; ignored when br_jump=1.
- br_pred  in  1  fetch predicted taken.
- br_pc  in  DWIDTH  PC of the branch instruction.
- br_rs1  in  DWIDTH  rs1 operand, JALR only.
- br_imm  in  DWIDTH  sign-extended offset.
- redirect_valid  out  1  corrected PC offered to fetch.
- redirect_ready  in  1  fetch accepts redirect_pc.
- redirect_pc  out  DWIDTH  corrected fetch PC.
- flush_ifid  out  1  squash IF/ID register.
- flush_idex  out  1  squash ID/EX register.
- stall_ex  out  1  hold EX stage.
- misalign_err  out  1  one-cycle pulse: taken target not 4-byte aligned.

Behaviour:
- Reset: all outputs 0 except br_ready, which is 1 (state IDLE). Counters cleared. Reset mid-operation abandons any redirect: no redirect_valid is emitted after reset deasserts.
- Arithmetic, modulo 2^DWIDTH (wraps, no overflow flag):
  - tgt = br_pc + br_imm; JALR: (br_rs1 + br_imm) with bit0 cleared.
  - seq = br_pc + 4.
- Decision when br_valid & br_ready:
  - take = br_jump | br_taken.
  - mispredict = br_jump ? 1 : (br_taken != br_pred).
  - newpc = take ? tgt : seq.
  - If take and tgt[1] = 1: misalign_err pulses next cycle. No redirect; stay IDLE. The exception path owns recovery.
  - Else if mispredict: latch newpc into redirect_pc; go to REDIRECT.
  - Else: no action; stay IDLE.
- States:
  - IDLE: br_ready=1; flush/stall/redirect_valid=0.
  - REDIRECT: redirect_valid=1, flush_ifid=1, flush_idex=1, stall_ex=1, br_ready=0. redirect_pc stable until accepted. Leave only on redirect_ready=1: to FLUSH with cnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else to IDLE.
  - FLUSH: flush_ifid=flush_idex=1, stall_ex=0, br_ready=0. cnt decrements each cycle; at cnt==0, go to IDLE next cycle.
- Latency: registered. redirect_valid rises the cycle after the accepted br_valid. Flush is asserted for exactly (cycles in REDIRECT) + (FLUSH_CYCLES-1) cycles.
- br_valid while br_ready=0: not accepted, no effect. EX must hold it (stall_ex covers REDIRECT).
- redirect_ready asserted in IDLE/FLUSH: ignored.
- Back-to-back mispredicts: the second branch is accepted only after returning to IDLE.

Optional Feature:
- Macro: BRANCH_CTRL_STATS_EN.
- With it: extra outputs stat_branches and stat_mispredicts, each 32-bit wrapping, reset to 0.
  - stat_branches increments on every accepted br_valid.
  - stat_mispredicts increments on every entry to REDIRECT. Misaligned targets are excluded.
- Without it: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared cpu package holds:
  - enum brctl_state_t {IDLE, REDIRECT, FLUSH}.
  - funct3-independent constants: PC_STEP = 4, JALR_MASK (~1).
- One natural sub-module, branch_target: combinational tgt/seq/newpc/misalign computation. It keeps the FSM file purely sequential.

Test Plan:
1. Conditional branch, br_pc=0x100, br_imm=0x20, br_taken=1, br_pred=0 -> redirect_valid next cycle, redirect_pc=0x120. With redirect_ready held 1, flush asserted 2 cycles total (FLUSH_CYCLES=2), then br_ready=1.
2. br_taken=0, br_pred=1, br_pc=0x200 -> redirect_pc=0x204. br_taken=br_pred=1 -> no redirect, no flush, br_ready stays 1.
3. JALR, br_rs1=0x1003, br_imm=0x4 -> redirect_pc=0x1006, misalign_err pulses, no redirect. br_rs1=0x1001, br_imm=0x3 -> redirect_pc=0x1004, redirect issued.
4. redirect_ready held 0 for 5 cycles -> redirect_valid, stall_ex and flushes held; redirect_pc unchanged. A second br_valid during this time is not accepted.
5. br_pc=0xFFFFFFF0, br_imm=0x20, taken mispredict -> redirect_pc=0x00000010 (wrap).
6. Assert reset while in REDIRECT -> all outputs 0 and br_ready=1 immediately; no redirect_valid after release. With BRANCH_CTRL_STATS_EN, both counters are 0.
